frame_block_reader: RTL and testbench



---
 rtl/frame_block_reader.sv | 172 +++++++++++++++++
 tb/tb_frame_block_reader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_block_reader.sv
// Walks FRAME_COUNT frame buffers block by block, issuing burst reads and handing
// each buffered block to a slow consumer under a blk_start/blk_done handshake.
module frame_block_reader #(
  parameter int unsigned MEM_DATA_BITS    = 32,
  parameter int unsigned ADDR_BITS        = 23,
  parameter int unsigned BURST_BITS       = 10,
  parameter int unsigned BURST_SIZE       = 128,
  parameter int unsigned BURSTS_PER_BLOCK = 2,
  parameter int unsigned BLOCKS_PER_FRAME = 1280,
  parameter int unsigned FRAME_COUNT      = 3,
  parameter int unsigned FRAME_STRIDE     = 2073600,
  localparam int unsigned FRAME_IDX_BITS  = (FRAME_COUNT > 1) ? $clog2(FRAME_COUNT) : 1
) (
  input  logic                      mem_clk,
  input  logic                      rst,
  input  logic                      frames_ready,
  input  logic                      loop_en,
  output logic                      rd_burst_req,
  output logic [BURST_BITS-1:0]     rd_burst_len,
  output logic [ADDR_BITS-1:0]      rd_burst_addr,
  input  logic                      rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0]  rd_burst_data,
  input  logic                      rd_burst_finish,
  output logic                      blk_data_valid,
  output logic [MEM_DATA_BITS-1:0]  blk_data,
  output logic                      blk_start,
  input  logic                      blk_done,
  output logic [FRAME_IDX_BITS-1:0] frame_idx,
  output logic                      frame_done,
  output logic                      pass_done
);

  localparam int unsigned BURST_CNT_BITS = (BURSTS_PER_BLOCK > 1) ? $clog2(BURSTS_PER_BLOCK) : 1;
  localparam int unsigned BLOCK_CNT_BITS = (BLOCKS_PER_FRAME > 1) ? $clog2(BLOCKS_PER_FRAME) : 1;

  localparam logic [BURST_CNT_BITS-1:0] LAST_BURST = BURST_CNT_BITS'(BURSTS_PER_BLOCK - 1);
  localparam logic [BLOCK_CNT_BITS-1:0] LAST_BLOCK = BLOCK_CNT_BITS'(BLOCKS_PER_FRAME - 1);
  localparam logic [FRAME_IDX_BITS-1:0] LAST_FRAME = FRAME_IDX_BITS'(FRAME_COUNT - 1);
  localparam logic [ADDR_BITS-1:0]      BURST_STEP = ADDR_BITS'(BURST_SIZE);
  localparam logic [ADDR_BITS-1:0]      FRAME_STEP = ADDR_BITS'(FRAME_STRIDE);

  typedef enum logic [1:0] {StIdle, StReq, StWaitBurst, StWaitConsumer} state_t;

  state_t                    state_q, state_d;
  logic [BURST_CNT_BITS-1:0] burst_cnt_q, burst_cnt_d;
  logic [BLOCK_CNT_BITS-1:0] block_cnt_q, block_cnt_d;
  logic [FRAME_IDX_BITS-1:0] frame_idx_q, frame_idx_d;
  logic [ADDR_BITS-1:0]      addr_q, addr_d;
  logic [ADDR_BITS-1:0]      frame_base_q, frame_base_d;
  logic                      req_q, req_d;
  logic                      blk_start_q, blk_start_d;
  logic                      frame_done_q, frame_done_d;
  logic                      pass_done_q, pass_done_d;
  logic                      blk_data_valid_q;
  logic [MEM_DATA_BITS-1:0]  blk_data_q;

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    block_cnt_d  = block_cnt_q;
    frame_idx_d  = frame_idx_q;
    addr_d       = addr_q;
    frame_base_d = frame_base_q;
    req_d        = req_q;
    blk_start_d  = blk_start_q;
    frame_done_d = 1'b0;
    pass_done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (frames_ready) begin
          state_d      = StReq;
          req_d        = 1'b1;
          burst_cnt_d  = '0;
          block_cnt_d  = '0;
          frame_idx_d  = '0;
          addr_d       = '0;
          frame_base_d = '0;
        end
      end
      StReq, StWaitBurst: begin
        // A finish with no preceding valid still completes the burst.
        if (rd_burst_finish) begin
          if (burst_cnt_q != LAST_BURST) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
            addr_d      = addr_q + BURST_STEP;
            req_d       = 1'b1;
            state_d     = StReq;
          end else begin
            burst_cnt_d = '0;
            req_d       = 1'b0;
            blk_start_d = 1'b1;
            state_d     = StWaitConsumer;
          end
        end else if (state_q == StReq && rd_burst_data_valid) begin
          req_d   = 1'b0;
          state_d = StWaitBurst;
        end
      end
      StWaitConsumer: begin
        if (blk_done) begin
          blk_start_d = 1'b0;
          if (block_cnt_q != LAST_BLOCK) begin
            block_cnt_d = block_cnt_q + 1'b1;
            addr_d      = addr_q + BURST_STEP;
            req_d       = 1'b1;
            state_d     = StReq;
          end else begin
            frame_done_d = 1'b1;
            block_cnt_d  = '0;
            if (frame_idx_q != LAST_FRAME) begin
              frame_idx_d  = frame_idx_q + 1'b1;
              frame_base_d = frame_base_q + FRAME_STEP;
              addr_d       = frame_base_q + FRAME_STEP;
              req_d        = 1'b1;
              state_d      = StReq;
            end else begin
              pass_done_d  = 1'b1;
              frame_idx_d  = '0;
              frame_base_d = '0;
              addr_d       = '0;
              req_d        = loop_en;
              state_d      = loop_en ? StReq : StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      burst_cnt_q      <= '0;
      block_cnt_q      <= '0;
      frame_idx_q      <= '0;
      addr_q           <= '0;
      frame_base_q     <= '0;
      req_q            <= 1'b0;
      blk_start_q      <= 1'b0;
      frame_done_q     <= 1'b0;
      pass_done_q      <= 1'b0;
      blk_data_valid_q <= 1'b0;
      blk_data_q       <= '0;
    end else begin
      state_q          <= state_d;
      burst_cnt_q      <= burst_cnt_d;
      block_cnt_q      <= block_cnt_d;
      frame_idx_q      <= frame_idx_d;
      addr_q           <= addr_d;
      frame_base_q     <= frame_base_d;
      req_q            <= req_d;
      blk_start_q      <= blk_start_d;
      frame_done_q     <= frame_done_d;
      pass_done_q      <= pass_done_d;
      blk_data_valid_q <= rd_burst_data_valid;
      blk_data_q       <= rd_burst_data;
    end
  end

  assign rd_burst_req   = req_q;
  assign rd_burst_len   = BURST_BITS'(BURST_SIZE);
  assign rd_burst_addr  = addr_q;
  assign blk_data_valid = blk_data_valid_q;
  assign blk_data       = blk_data_q;
  assign blk_start      = blk_start_q;
  assign frame_idx      = frame_idx_q;
  assign frame_done     = frame_done_q;
  assign pass_done      = pass_done_q;

endmodule

// File: tb/tb_frame_block_reader.sv
// Scoreboard bench for frame_block_reader: randomized memory and consumer models feed
// expected addresses, data and handshake outcomes into queues checked by a monitor.
module tb_frame_block_reader;

  localparam int unsigned BS = 4, BPB = 2, BPF = 3, FC = 2, STRIDE = 100;
  localparam int unsigned AW = 23, DW = 32, BB = 10;

  logic          mem_clk = 1'b0, rst = 1'b1, frames_ready = 1'b0, loop_en = 1'b0;
  logic          rd_burst_data_valid = 1'b0, rd_burst_finish = 1'b0, blk_done = 1'b0;
  logic [DW-1:0] rd_burst_data = '0;
  logic          rd_burst_req, blk_data_valid, blk_start, frame_done, pass_done;
  logic [BB-1:0] rd_burst_len;
  logic [AW-1:0] rd_burst_addr;
  logic [DW-1:0] blk_data;
  logic [0:0]    frame_idx;

  frame_block_reader #(
    .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .BURST_BITS(BB), .BURST_SIZE(BS),
    .BURSTS_PER_BLOCK(BPB), .BLOCKS_PER_FRAME(BPF), .FRAME_COUNT(FC), .FRAME_STRIDE(STRIDE)
  ) dut (
    .mem_clk(mem_clk), .rst(rst), .frames_ready(frames_ready), .loop_en(loop_en),
    .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
    .rd_burst_finish(rd_burst_finish), .blk_data_valid(blk_data_valid), .blk_data(blk_data),
    .blk_start(blk_start), .blk_done(blk_done), .frame_idx(frame_idx),
    .frame_done(frame_done), .pass_done(pass_done)
  );

  always #5 mem_clk = ~mem_clk;

  typedef struct { bit lf; bit lp; int fi; } done_exp_t;

  int unsigned vectors = 0, miscompares = 0;
  int          n_fd = 0, n_pd = 0, n_bs = 0;
  int          blk_no = 0;
  bit          long_next = 1'b0, hold_104 = 1'b0, inject_finish = 1'b0;
  int unsigned exp_addr[$];
  logic [31:0] exp_data[$];
  done_exp_t   exp_done[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference address sequence for one full pass.
  task automatic push_pass();
    for (int f = 0; f < FC; f++)
      for (int b = 0; b < BPF; b++)
        for (int k = 0; k < BPB; k++)
          exp_addr.push_back(f * STRIDE + (b * BPB + k) * BS);
  endtask

  // Memory controller model.
  task automatic rtick();
    @(posedge mem_clk); #1;
    rd_burst_data       = $urandom();
    rd_burst_data_valid = 1'b0;
    rd_burst_finish     = 1'b0;
  endtask

  task automatic serve();
    int mode, dly;
    dly = $urandom_range(0, 2);
    repeat (dly) begin
      rtick();
      if (rst) return;
    end
    mode = $urandom_range(0, 3);
    if (mode == 0) begin
      rd_burst_data_valid = 1'b1;
      rd_burst_finish     = 1'b1;
      exp_data.push_back(rd_burst_data);
    end else if (mode == 1) begin
      rd_burst_finish = 1'b1;
    end else begin
      for (int i = 0; i < BS; i++) begin
        if (i > 0) begin
          rtick();
          if (rst) return;
        end
        rd_burst_data_valid = 1'b1;
        exp_data.push_back(rd_burst_data);
      end
      rtick();
      if (rst) return;
      rd_burst_finish = 1'b1;
    end
  endtask

  initial begin
    forever begin
      rtick();
      if (inject_finish) rd_burst_finish = 1'b1;
      else if (!rst && rd_burst_req && !(hold_104 && rd_burst_addr == 23'd104)) serve();
    end
  end

  // Consumer model.
  initial begin
    forever begin
      @(posedge mem_clk); #1;
      blk_done = 1'b0;
      if (!rst && blk_start) begin : consume
        int d;
        done_exp_t e;
        d = long_next ? 200 : $urandom_range(1, 8);
        long_next = 1'b0;
        repeat (d) begin @(posedge mem_clk); #1; end
        blk_done = 1'b1;
        e.lf = (blk_no % BPF) == BPF - 1;
        e.lp = blk_no == BPF * FC - 1;
        e.fi = e.lf ? (e.lp ? 0 : blk_no / BPF + 1) : blk_no / BPF;
        exp_done.push_back(e);
        blk_no = e.lp ? 0 : blk_no + 1;
      end
    end
  end

  // Monitor: prev-cycle inputs are what the DUT sampled at the edge in between.
  initial begin
    logic p_req, p_fin, p_done, p_start, p_rst, p_loop, p_inj;
    logic [31:0] p_data;
    done_exp_t e;
    p_req = 0; p_fin = 0; p_done = 0; p_start = 0; p_rst = 1; p_loop = 0; p_inj = 0; p_data = 0;
    forever begin
      @(negedge mem_clk);
      if (!rst && !p_rst) begin
        check("burst_len", 32'(rd_burst_len), BS);
        check("blk_data_delay", blk_data, p_data);
        if (blk_data_valid) begin
          if (exp_data.size() == 0) check("blk_data_extra", 32'(blk_data_valid), 0);
          else check("blk_data_sb", blk_data, exp_data.pop_front());
        end
        if (rd_burst_req && (!p_req || p_fin)) begin
          if (exp_addr.size() == 0) check("req_unexpected", 32'(rd_burst_req), 0);
          else check("burst_addr", 32'(rd_burst_addr), exp_addr.pop_front());
        end
        if (p_fin && !p_inj) check("finish_to_next", 32'(rd_burst_req | blk_start), 1);
        if (blk_start) check("no_req_while_blk_start", 32'(rd_burst_req), 0);
        if (p_done && p_start) begin
          if (exp_done.size() == 0) check("done_unexpected", 32'(p_done), 0);
          else begin
            e = exp_done.pop_front();
            check("done_blk_start_low", 32'(blk_start), 0);
            check("done_next_req", 32'(rd_burst_req), 32'(!e.lp || p_loop));
            check("done_frame_done", 32'(frame_done), 32'(e.lf));
            check("done_pass_done", 32'(pass_done), 32'(e.lp));
            check("done_frame_idx", 32'(frame_idx), e.fi);
          end
        end
        if (frame_done) n_fd++;
        if (pass_done) n_pd++;
        if (blk_start && !p_start) n_bs++;
      end
      p_req = rd_burst_req; p_fin = rd_burst_finish; p_done = blk_done; p_start = blk_start;
      p_rst = rst; p_loop = loop_en; p_inj = inject_finish; p_data = rd_burst_data;
    end
  end

  task automatic mtick();
    @(posedge mem_clk); #1;
  endtask

  task automatic start_pass();
    frames_ready = 1'b1;
    mtick();
    check("frames_ready_to_req", 32'(rd_burst_req), 1);
    frames_ready = 1'b0;
  endtask

  task automatic wait_passes(input int n);
    for (int i = 0; i < 4000 && n_pd < n; i++) mtick();
    check("pass_done_count", n_pd, n);
  endtask

  task automatic check_idle();
    int seen = 0;
    repeat (10) begin
      mtick();
      if (rd_burst_req || blk_start) seen++;
    end
    check("idle_after_pass", seen, 0);
  endtask

  task automatic clear_counts();
    n_fd = 0; n_pd = 0; n_bs = 0;
  endtask

  task automatic check_end(input int fd, input int bs);
    check("frame_done_count", n_fd, fd);
    check("blk_start_count", n_bs, bs);
    check("addr_queue_drained", exp_addr.size(), 0);
    check("done_queue_drained", exp_done.size(), 0);
  endtask

  initial begin
    int reached;
    repeat (3) @(negedge mem_clk);
    check("rst_req", 32'(rd_burst_req), 0);
    check("rst_len", 32'(rd_burst_len), BS);
    check("rst_addr", 32'(rd_burst_addr), 0);
    check("rst_blk_valid", 32'(blk_data_valid), 0);
    check("rst_blk_data", blk_data, 0);
    check("rst_blk_start", 32'(blk_start), 0);
    check("rst_frame_idx", 32'(frame_idx), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_pass_done", 32'(pass_done), 0);
    #2 rst = 1'b0;
    mtick();

    // Single pass with one very slow consumer block.
    clear_counts();
    long_next = 1'b1;
    push_pass();
    start_pass();
    wait_passes(1);
    check_idle();
    check_end(2, 6);

    // Loop mode: two back-to-back passes, then drop loop_en.
    clear_counts();
    loop_en = 1'b1;
    push_pass();
    push_pass();
    start_pass();
    wait_passes(1);
    loop_en = 1'b0;
    wait_passes(2);
    check_idle();
    check_end(4, 12);

    // Reset while a request is pending at address 104.
    clear_counts();
    hold_104 = 1'b1;
    for (int i = 0; i < 8; i++) exp_addr.push_back(i < 6 ? i * BS : STRIDE + (i - 6) * BS);
    start_pass();
    reached = 0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      mtick();
      reached = int'(rd_burst_req && rd_burst_addr == 23'd104);
    end
    check("reached_addr_104", reached, 1);
    @(negedge mem_clk); #2;
    rst = 1'b1;
    exp_data.delete();
    exp_done.delete();
    exp_addr.delete();
    blk_no = 0;
    #1;
    check("mid_rst_req", 32'(rd_burst_req), 0);
    check("mid_rst_addr", 32'(rd_burst_addr), 0);
    check("mid_rst_frame_idx", 32'(frame_idx), 0);
    hold_104 = 1'b0;
    repeat (2) @(negedge mem_clk);
    #2 rst = 1'b0;
    @(negedge mem_clk); #2 inject_finish = 1'b1;
    @(negedge mem_clk); #2 inject_finish = 1'b0;
    check_idle();
    clear_counts();
    push_pass();
    start_pass();
    wait_passes(1);
    check_idle();
    check_end(2, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1);
  end

endmodule
